// File: rtl/aqalu_arbiter.sv
// aqalu_arbiter: round-robin sharing of one AQALU between NUM_REQ requesters.
// Each requester hands over {A,B,Opcode} on a valid/ready channel. The winner's
// operands drive the AQALU pins, Output is sampled ALU_LAT cycles later, and the
// result goes back on one shared response channel, tagged with the requester id.
// Reserved opcodes (4'b1110, 4'b1111) are answered at once with rsp_err=1.
// Optional build macro AQALU_ARB_STATS_EN adds saturating per-requester grant
// counters (stat_grants) and a reserved-opcode counter (stat_errs).
module aqalu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ALU_LAT = 1,
   parameter int ID_W    = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [2*NUM_REQ-1:0]   req_a,
   input  logic [2*NUM_REQ-1:0]   req_b,
   input  logic [4*NUM_REQ-1:0]   req_op,
   output logic [1:0]             alu_a,
   output logic [1:0]             alu_b,
   output logic [3:0]             alu_opcode,
   input  logic [7:0]             alu_result,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [7:0]             rsp_data,
   output logic                   rsp_err
`ifdef AQALU_ARB_STATS_EN
   ,
   output logic [16*NUM_REQ-1:0]  stat_grants,
   output logic [15:0]            stat_errs
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

   if (ALU_LAT < 1) begin : g_bad_lat
      $error("aqalu_arbiter: ALU_LAT must be at least 1");
   end
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num
      $error("aqalu_arbiter: NUM_REQ must be in 2..8");
   end
   if (ID_W < PTR_W) begin : g_bad_id
      $error("aqalu_arbiter: ID_W too narrow for NUM_REQ");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [CNT_W-1:0] lat_cnt;

   logic             win_found;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] next_ptr;
   logic [PTR_W-1:0] cand;
   int               idx;

   logic [1:0]       cmd_a  [NUM_REQ];
   logic [1:0]       cmd_b  [NUM_REQ];
   logic [3:0]       cmd_op [NUM_REQ];
   logic [1:0]       sel_a;
   logic [1:0]       sel_b;
   logic [3:0]       sel_op;
   logic             sel_rsvd;

   // Unpack the flat per-requester command buses into indexable arrays.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign cmd_a[g]  = req_a[2*g +: 2];
      assign cmd_b[g]  = req_b[2*g +: 2];
      assign cmd_op[g] = req_op[4*g +: 4];
   end

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         cand = PTR_W'(idx);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Winner's command, its reserved-opcode flag and the pointer after it.
   always_comb begin
      sel_a    = cmd_a[win_idx];
      sel_b    = cmd_b[win_idx];
      sel_op   = cmd_op[win_idx];
      sel_rsvd = (sel_op[3:1] == 3'b111);
      next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
   end

   // Grant is combinational in IDLE; held off while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (reset && state == IDLE && win_found) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Control FSM with registered ALU pins and response outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         lat_cnt    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  rsp_id <= ID_W'(win_idx);
                  rr_ptr <= next_ptr;
                  if (sel_rsvd) begin
                     // No ALU op: answer immediately and leave the ALU pins alone.
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     alu_a      <= sel_a;
                     alu_b      <= sel_b;
                     alu_opcode <= sel_op;
                     lat_cnt    <= CNT_W'(ALU_LAT);
                     state      <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (lat_cnt == CNT_W'(1)) begin
                  rsp_data  <= alu_result;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  lat_cnt   <= '0;
                  state     <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef AQALU_ARB_STATS_EN
   logic [15:0] grant_cnt [NUM_REQ];
   logic [15:0] err_cnt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating grant/error counters, bumped on every grant handshake.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant_cnt <= '{default: '0};
         err_cnt   <= '0;
      end else if (state == IDLE && win_found) begin
         grant_cnt[win_idx] <= sat_inc(grant_cnt[win_idx]);
         if (sel_rsvd) begin
            err_cnt <= sat_inc(err_cnt);
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_grants[16*g +: 16] = grant_cnt[g];
   end
   assign stat_errs = err_cnt;
`endif

endmodule

// File: tb/tb_aqalu_arbiter.sv
// tb_aqalu_arbiter: directed and randomized checks of aqalu_arbiter against a
// transaction-level round-robin model and a registered AQALU stand-in.
module tb_aqalu_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ALU_LAT = 2;
   localparam int ID_W    = 1;

   logic                 clock;
   logic                 reset;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [2*NUM_REQ-1:0] req_a;
   logic [2*NUM_REQ-1:0] req_b;
   logic [4*NUM_REQ-1:0] req_op;
   logic [1:0]           alu_a;
   logic [1:0]           alu_b;
   logic [3:0]           alu_opcode;
   logic [7:0]           alu_result;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [7:0]           rsp_data;
   logic                 rsp_err;
`ifdef AQALU_ARB_STATS_EN
   logic [16*NUM_REQ-1:0] stat_grants;
   logic [15:0]           stat_errs;
`endif

   int total = 0;
   int bad   = 0;

   logic [1:0] a_arr  [NUM_REQ];
   logic [1:0] b_arr  [NUM_REQ];
   logic [3:0] op_arr [NUM_REQ];
   logic [1:0] la;
   logic [1:0] lb;
   logic [3:0] lop;
   int         model_ptr;
   logic [7:0] alu_q;

   aqalu_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ALU_LAT (ALU_LAT),
      .ID_W    (ID_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err)
`ifdef AQALU_ARB_STATS_EN
      ,
      .stat_grants (stat_grants),
      .stat_errs   (stat_errs)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Stand-in AQALU function of the operands.
   function automatic logic [7:0] alu_fn(input logic [1:0] a, input logic [1:0] b,
                                         input logic [3:0] op);
      return {op, a, b} ^ 8'hA5;
   endfunction

   // Stand-in AQALU with one register stage: Output is valid on the second
   // cycle of stable operands, matching ALU_LAT=2.
   always @(posedge clock) alu_q <= alu_fn(alu_a, alu_b, alu_opcode);
   assign alu_result = alu_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".req_ready"},  32'(req_ready),  32'(0));
      chk({tag, ".alu_a"},      32'(alu_a),      32'(0));
      chk({tag, ".alu_b"},      32'(alu_b),      32'(0));
      chk({tag, ".alu_opcode"}, 32'(alu_opcode), 32'(0));
      chk({tag, ".rsp_valid"},  32'(rsp_valid),  32'(0));
      chk({tag, ".rsp_id"},     32'(rsp_id),     32'(0));
      chk({tag, ".rsp_data"},   32'(rsp_data),   32'(0));
      chk({tag, ".rsp_err"},    32'(rsp_err),    32'(0));
   endtask

   task automatic set_cmd(input int i, input logic [1:0] a, input logic [1:0] b,
                          input logic [3:0] op);
      a_arr[i]  = a;
      b_arr[i]  = b;
      op_arr[i] = op;
      req_a  = {a_arr[1], a_arr[0]};
      req_b  = {b_arr[1], b_arr[0]};
      req_op = {op_arr[1], op_arr[0]};
   endtask

   // Reference winner: first valid requester scanning upward from ptr, wrapping.
   function automatic int rr_pick(input logic [NUM_REQ-1:0] vld, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (vld[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // One complete transaction: grant, ALU drive, response (with bp stall cycles), retire.
   task automatic do_op(input logic [NUM_REQ-1:0] vld, input int win, input int bp);
      logic [1:0] ea;
      logic [1:0] eb;
      logic [3:0] eo;
      logic       rsvd;
      logic [7:0] ed;
      ea   = a_arr[win];
      eb   = b_arr[win];
      eo   = op_arr[win];
      rsvd = (eo == 4'b1110) || (eo == 4'b1111);
      req_valid = vld;
      #1;
      chk("grant", 32'(req_ready), 32'(1) << win);
      @(negedge clock);
      if (rsvd) begin
         chk("alu_a_hold",  32'(alu_a),      32'(la));
         chk("alu_b_hold",  32'(alu_b),      32'(lb));
         chk("alu_op_hold", 32'(alu_opcode), 32'(lop));
         ed = 8'h00;
      end else begin
         chk("alu_a",  32'(alu_a),      32'(ea));
         chk("alu_b",  32'(alu_b),      32'(eb));
         chk("alu_op", 32'(alu_opcode), 32'(eo));
         la  = ea;
         lb  = eb;
         lop = eo;
         for (int c = 1; c <= ALU_LAT; c++) begin
            chk("early_rsp",  32'(rsp_valid), 32'(0));
            chk("ready_exec", 32'(req_ready), 32'(0));
            @(negedge clock);
         end
         ed = alu_fn(ea, eb, eo);
      end
      for (int c = 0; c <= bp; c++) begin
         chk("rsp_valid",  32'(rsp_valid), 32'(1));
         chk("rsp_id",     32'(rsp_id),    32'(win));
         chk("rsp_data",   32'(rsp_data),  32'(ed));
         chk("rsp_err",    32'(rsp_err),   32'(rsvd));
         chk("ready_resp", 32'(req_ready), 32'(0));
         if (c < bp) @(negedge clock);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      chk("rsp_retire", 32'(rsp_valid), 32'(0));
      model_ptr = (win + 1) % NUM_REQ;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 1'b0;
      model_ptr = 0;
      la = '0; lb = '0; lop = '0;
      set_cmd(0, 2'd0, 2'd0, 4'd0);
      set_cmd(1, 2'd0, 2'd0, 4'd0);

      // Reset with both requesters asserting valid
      #2 reset = 1'b0;
      repeat (3) @(negedge clock);
      chk_zero("rst");
      reset = 1'b1;
      #1;
      chk("rst_release_ready", 32'(req_ready), 32'(2'b01));
      req_valid = '0;

      // Single op from requester 0
      set_cmd(0, 2'd2, 2'd1, 4'd0);
      do_op(2'b01, 0, 0);

      // Reserved opcode from requester 1; ALU pins keep the previous op
      set_cmd(1, 2'd3, 2'd3, 4'b1111);
      do_op(2'b10, 1, 0);

      // Contention: order 0,1,0,1 then back-pressure, then grant resumes
      set_cmd(0, 2'd1, 2'd3, 4'd5);
      set_cmd(1, 2'd3, 2'd2, 4'd9);
      do_op(2'b11, 0, 0);
      do_op(2'b11, 1, 0);
      set_cmd(0, 2'd0, 2'd2, 4'd12);
      do_op(2'b11, 0, 0);
      do_op(2'b11, 1, 5);
      do_op(2'b11, 0, 0);
      req_valid = '0;

      // Mid-op reset: grant req0 (wrapping from pointer 1), reset in EXEC
      set_cmd(0, 2'd1, 2'd1, 4'd3);
      req_valid = 2'b01;
      #1;
      chk("grant_wrap", 32'(req_ready), 32'(2'b01));
      @(negedge clock);
      chk("exec_alu_op", 32'(alu_opcode), 32'(4'd3));
      reset = 1'b0;
      #1;
      chk_zero("rst_exec");
      req_valid = '0;
      repeat (3) begin
         @(negedge clock);
         chk("no_rsp_after_rst", 32'(rsp_valid), 32'(0));
      end
      reset = 1'b1;
      la = '0; lb = '0; lop = '0;
      model_ptr = 0;
      req_valid = 2'b11;
      #1;
      chk("ptr_after_rst", 32'(req_ready), 32'(2'b01));
      req_valid = '0;

      // Three ops from req0, one reserved op from req1
      set_cmd(0, 2'd1, 2'd2, 4'd1);
      do_op(2'b01, 0, 0);
      set_cmd(0, 2'd3, 2'd0, 4'd7);
      do_op(2'b01, 0, 1);
      set_cmd(0, 2'd2, 2'd2, 4'd13);
      do_op(2'b01, 0, 0);
      set_cmd(1, 2'd2, 2'd3, 4'b1110);
      do_op(2'b10, 1, 0);
      req_valid = '0;
`ifdef AQALU_ARB_STATS_EN
      chk("stat_grants", 32'(stat_grants), 32'({16'd1, 16'd3}));
      chk("stat_errs",   32'(stat_errs),   32'(16'd1));
`endif

      // Randomized traffic against the round-robin reference
      for (int it = 0; it < 60; it++) begin
         logic [NUM_REQ-1:0] v;
         int                 w;
         for (int i = 0; i < NUM_REQ; i++) begin
            set_cmd(i, 2'($urandom), 2'($urandom), 4'($urandom));
         end
         v = NUM_REQ'($urandom_range(0, 3));
         w = rr_pick(v, model_ptr);
         if (w < 0) begin
            req_valid = '0;
            #1;
            chk("idle_no_grant", 32'(req_ready), 32'(0));
            @(negedge clock);
            chk("idle_no_rsp", 32'(rsp_valid), 32'(0));
         end else begin
            do_op(v, w, int'($urandom_range(0, 2)));
         end
      end
      req_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
